// File: rtl/bc_pkg.sv
// Shared types, constants and width helpers for the bulls-and-cows engine.
package bc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_SCORE,
      ST_DONE
   } state_e;

   localparam int unsigned          DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0]   BCD_MAX = 4'd9;

   function automatic int unsigned bw_f(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic int unsigned cw_f(input int unsigned n);
      return $clog2(n * (n - 1) + 1);
   endfunction

endpackage

// File: rtl/bulls_cows_engine_if.sv
// Guess/score bus between the bulls-and-cows engine and its driver/display side.
interface bulls_cows_engine_if #(
   parameter int unsigned NUM_DIGITS = 3
);
   localparam int unsigned BW     = bc_pkg::bw_f(NUM_DIGITS);
   localparam int unsigned CW     = bc_pkg::cw_f(NUM_DIGITS);
   localparam int unsigned CODE_W = bc_pkg::DIGIT_W * NUM_DIGITS;

   logic [CODE_W-1:0] in_digits;
   logic              in_valid;
   logic              in_ready;
   logic              new_game;
   logic [BW-1:0]     bulls;
   logic [CW-1:0]     cows;
   logic              score_valid;
   logic              rejected;
   logic [7:0]        tries;
   logic              game_active;
   logic              game_won;
   logic              game_lost;
   logic [CODE_W-1:0] last_guess;

   modport slave (
      input  in_digits, in_valid, new_game,
      output in_ready, bulls, cows, score_valid, rejected, tries,
             game_active, game_won, game_lost, last_guess
   );

   modport master (
      output in_digits, in_valid, new_game,
      input  in_ready, bulls, cows, score_valid, rejected, tries,
             game_active, game_won, game_lost, last_guess
   );

endinterface

// File: rtl/bc_digit_cmp.sv
// Scores one guess digit at position idx_i against the whole answer code.
module bc_digit_cmp
   import bc_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned BW         = bw_f(NUM_DIGITS)
) (
   input  logic [DIGIT_W-1:0]            g_digit_i,
   input  logic [BW-1:0]                 idx_i,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] ans_i,
   output logic                          bull_o,
   output logic [BW-1:0]                 cow_o
);

   always_comb begin
      bull_o = 1'b0;
      cow_o  = '0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         if (ans_i[DIGIT_W*(NUM_DIGITS-1-j) +: DIGIT_W] == g_digit_i) begin
            if (idx_i == BW'(j)) bull_o = 1'b1;
            else                 cow_o  = cow_o + BW'(1);
         end
      end
   end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls-and-cows game engine: latches an answer, scores guesses one digit per cycle.
// Define BC_DUP_CHECK_EN to also refuse codes containing a repeated digit.
module bulls_cows_engine
   import bc_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 3,
   parameter int unsigned MAX_TRIES  = 10
) (
   input logic                clk,
   input logic                reset,
   bulls_cows_engine_if.slave bus
);

   localparam int unsigned BW     = bw_f(NUM_DIGITS);
   localparam int unsigned CW     = cw_f(NUM_DIGITS);
   localparam int unsigned CODE_W = DIGIT_W * NUM_DIGITS;

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   answer_q, answer_d;
   logic [CODE_W-1:0]   guess_q, guess_d;
   logic [BW-1:0]       idx_q, idx_d;
   logic [BW-1:0]       bacc_q, bacc_d;
   logic [CW-1:0]       cacc_q, cacc_d;
   logic [BW-1:0]       bulls_q, bulls_d;
   logic [CW-1:0]       cows_q, cows_d;
   logic [7:0]          tries_q, tries_d;
   logic                won_q, won_d;
   logic                lost_q, lost_d;
   logic                score_valid_q, score_valid_d;
   logic                rejected_q, rejected_d;

   logic                code_ok;
   logic [7:0]          tries_inc;
   logic [DIGIT_W-1:0]  cur_digit;
   logic                cmp_bull;
   logic [BW-1:0]       cmp_cow;

   always_comb begin
      code_ok = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (bus.in_digits[DIGIT_W*i +: DIGIT_W] > BCD_MAX) code_ok = 1'b0;
      end
`ifdef BC_DUP_CHECK_EN
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         for (int unsigned j = i + 1; j < NUM_DIGITS; j++) begin
            if (bus.in_digits[DIGIT_W*i +: DIGIT_W] == bus.in_digits[DIGIT_W*j +: DIGIT_W])
               code_ok = 1'b0;
         end
      end
`endif
   end

   // idx_q == NUM_DIGITS selects nothing; that extra cycle publishes the score.
   always_comb begin
      cur_digit = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == BW'(i)) cur_digit = guess_q[DIGIT_W*(NUM_DIGITS-1-i) +: DIGIT_W];
      end
   end

   bc_digit_cmp #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_cmp (
      .g_digit_i (cur_digit),
      .idx_i     (idx_q),
      .ans_i     (answer_q),
      .bull_o    (cmp_bull),
      .cow_o     (cmp_cow)
   );

   assign tries_inc = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;

   always_comb begin
      state_d       = state_q;
      answer_d      = answer_q;
      guess_d       = guess_q;
      idx_d         = idx_q;
      bacc_d        = bacc_q;
      cacc_d        = cacc_q;
      bulls_d       = bulls_q;
      cows_d        = cows_q;
      tries_d       = tries_q;
      won_d         = won_q;
      lost_d        = lost_q;
      score_valid_d = 1'b0;
      rejected_d    = 1'b0;

      if (bus.new_game) begin
         state_d  = ST_IDLE;
         answer_d = '0;
         guess_d  = '0;
         idx_d    = '0;
         bacc_d   = '0;
         cacc_d   = '0;
         bulls_d  = '0;
         cows_d   = '0;
         tries_d  = '0;
         won_d    = 1'b0;
         lost_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  if (!code_ok) begin
                     rejected_d = 1'b1;
                  end else begin
                     answer_d = bus.in_digits;
                     tries_d  = '0;
                     state_d  = ST_PLAY;
                  end
               end
            end
            ST_PLAY: begin
               if (bus.in_valid) begin
                  if (!code_ok) begin
                     rejected_d = 1'b1;
                  end else begin
                     guess_d = bus.in_digits;
                     idx_d   = '0;
                     bacc_d  = '0;
                     cacc_d  = '0;
                     state_d = ST_SCORE;
                  end
               end
            end
            ST_SCORE: begin
               if (idx_q == BW'(NUM_DIGITS)) begin
                  bulls_d       = bacc_q;
                  cows_d        = cacc_q;
                  score_valid_d = 1'b1;
                  tries_d       = tries_inc;
                  if (bacc_q == BW'(NUM_DIGITS)) begin
                     won_d   = 1'b1;
                     state_d = ST_DONE;
                  end else if (tries_inc == 8'(MAX_TRIES)) begin
                     lost_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_PLAY;
                  end
               end else begin
                  bacc_d = bacc_q + BW'(cmp_bull);
                  cacc_d = cacc_q + CW'(cmp_cow);
                  idx_d  = idx_q + BW'(1);
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         answer_q      <= '0;
         guess_q       <= '0;
         idx_q         <= '0;
         bacc_q        <= '0;
         cacc_q        <= '0;
         bulls_q       <= '0;
         cows_q        <= '0;
         tries_q       <= '0;
         won_q         <= 1'b0;
         lost_q        <= 1'b0;
         score_valid_q <= 1'b0;
         rejected_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         answer_q      <= answer_d;
         guess_q       <= guess_d;
         idx_q         <= idx_d;
         bacc_q        <= bacc_d;
         cacc_q        <= cacc_d;
         bulls_q       <= bulls_d;
         cows_q        <= cows_d;
         tries_q       <= tries_d;
         won_q         <= won_d;
         lost_q        <= lost_d;
         score_valid_q <= score_valid_d;
         rejected_q    <= rejected_d;
      end
   end

   assign bus.in_ready    = (state_q == ST_IDLE) || (state_q == ST_PLAY);
   assign bus.game_active = (state_q == ST_PLAY) || (state_q == ST_SCORE);
   assign bus.bulls       = bulls_q;
   assign bus.cows        = cows_q;
   assign bus.score_valid = score_valid_q;
   assign bus.rejected    = rejected_q;
   assign bus.tries       = tries_q;
   assign bus.game_won    = won_q;
   assign bus.game_lost   = lost_q;
   assign bus.last_guess  = guess_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Scoreboard bench for bulls_cows_engine (NUM_DIGITS=3, MAX_TRIES=10).
module tb_bulls_cows_engine;

   typedef struct {
      logic [1:0] b;
      logic [2:0] c;
      logic [7:0] t;
      logic       act;
      logic       won;
      logic       lost;
      int         cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   exp_t sq[$];
   int   rq[$];
   exp_t mon_e;
   int   mon_r;

   bulls_cows_engine_if #(.NUM_DIGITS(3)) bus ();

   bulls_cows_engine #(
      .NUM_DIGITS (3),
      .MAX_TRIES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int b, input int c, input int t,
                               input bit act, input bit won, input bit lost);
      exp_t e;
      e.b = 2'(b); e.c = 3'(c); e.t = 8'(t);
      e.act = act; e.won = won; e.lost = lost; e.cyc = 0;
      return e;
   endfunction

   // kind: 0 = no response, 1 = score expected, 2 = rejection expected
   task automatic send(input logic [11:0] code, input int kind, input exp_t e);
      exp_t q;
      q = e;
      @(negedge clk);
      bus.in_digits = code;
      bus.in_valid  = 1'b1;
      if (kind == 1) begin
         q.cyc = cyc + 5;
         sq.push_back(q);
      end else if (kind == 2) begin
         rq.push_back(cyc + 1);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (sq.size() == 0 && rq.size() == 0) return;
      end
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sq.size() + rq.size());
      sq.delete();
      rq.delete();
   endtask

   task automatic pulse_new_game();
      @(negedge clk);
      bus.new_game = 1'b1;
      @(negedge clk);
      bus.new_game = 1'b0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
      chk({tag, "_bulls"}, 32'(bus.bulls), 0);
      chk({tag, "_cows"}, 32'(bus.cows), 0);
      chk({tag, "_tries"}, 32'(bus.tries), 0);
      chk({tag, "_active"}, 32'(bus.game_active), 0);
      chk({tag, "_won"}, 32'(bus.game_won), 0);
      chk({tag, "_lost"}, 32'(bus.game_lost), 0);
      chk({tag, "_last_guess"}, 32'(bus.last_guess), 0);
      chk({tag, "_score_valid"}, 32'(bus.score_valid), 0);
      chk({tag, "_rejected"}, 32'(bus.rejected), 0);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.score_valid) begin
            if (sq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_score: got score_valid=1 expected 0");
            end else begin
               mon_e = sq.pop_front();
               chk("score_cycle", 32'(cyc), 32'(mon_e.cyc));
               chk("bulls", 32'(bus.bulls), 32'(mon_e.b));
               chk("cows", 32'(bus.cows), 32'(mon_e.c));
               chk("tries", 32'(bus.tries), 32'(mon_e.t));
               chk("game_active", 32'(bus.game_active), 32'(mon_e.act));
               chk("game_won", 32'(bus.game_won), 32'(mon_e.won));
               chk("game_lost", 32'(bus.game_lost), 32'(mon_e.lost));
            end
         end
         if (bus.rejected) begin
            if (rq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_reject: got rejected=1 expected 0");
            end else begin
               mon_r = rq.pop_front();
               chk("reject_cycle", 32'(cyc), 32'(mon_r));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.in_digits = '0;
      bus.in_valid  = 1'b0;
      bus.new_game  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_cleared("reset");

      // answer then a partial match
      send(12'h123, 0, mk(0, 0, 0, 0, 0, 0));
      chk("play_active", 32'(bus.game_active), 1);
      chk("play_tries", 32'(bus.tries), 0);
      send(12'h132, 1, mk(1, 2, 1, 1, 0, 0));
      drain();
      chk("last_guess_132", 32'(bus.last_guess), 32'h132);

      // non-BCD digit refused in PLAY
      send(12'h1A3, 2, mk(0, 0, 0, 0, 0, 0));
      drain();
      chk("reject_tries", 32'(bus.tries), 1);
      chk("reject_last_guess", 32'(bus.last_guess), 32'h132);

      // winning guess, then offers ignored in DONE
      send(12'h123, 1, mk(3, 0, 2, 0, 1, 0));
      drain();
      chk("done_in_ready", 32'(bus.in_ready), 0);
      send(12'h456, 0, mk(0, 0, 0, 0, 0, 0));
      repeat (6) @(negedge clk);
      chk("done_last_guess", 32'(bus.last_guess), 32'h123);
      chk("done_tries", 32'(bus.tries), 2);
      chk("done_won", 32'(bus.game_won), 1);

      // loss after MAX_TRIES misses
      pulse_new_game();
      chk_cleared("new_game");
      send(12'h123, 0, mk(0, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 10; i++) begin
         send(12'h456, 1, mk(0, 0, i, (i < 10), 0, (i == 10)));
         drain();
      end
      chk("lost_flag", 32'(bus.game_lost), 1);
      chk("lost_tries", 32'(bus.tries), 10);
      chk("lost_in_ready", 32'(bus.in_ready), 0);

      // repeated digits in the guess
      pulse_new_game();
      send(12'h123, 0, mk(0, 0, 0, 0, 0, 0));
`ifdef BC_DUP_CHECK_EN
      send(12'h112, 2, mk(0, 0, 0, 0, 0, 0));
      drain();
      chk("dup_tries", 32'(bus.tries), 0);
`else
      send(12'h112, 1, mk(1, 2, 1, 1, 0, 0));
      drain();
`endif

      // new_game in the 2nd SCORE cycle
      send(12'h456, 0, mk(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      bus.new_game = 1'b1;
      @(negedge clk);
      bus.new_game = 1'b0;
      chk_cleared("mid_new_game");
      repeat (8) @(negedge clk);
      chk("mid_new_game_idle", 32'(bus.in_ready), 1);

      // reset in the 2nd SCORE cycle
      send(12'h123, 0, mk(0, 0, 0, 0, 0, 0));
      send(12'h456, 0, mk(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_cleared("mid_reset");
      repeat (8) @(negedge clk);
      chk("mid_reset_tries", 32'(bus.tries), 0);

      chk("score_queue_empty", 32'(sq.size()), 0);
      chk("reject_queue_empty", 32'(rq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bulls_cows_engine.md
BULLS_COWS_ENGINE -- requirements
Module: bulls_cows_engine

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, number of digits per code (legal 2..8).
REQ-002 SHALL have parameter MAX_TRIES, default 10, number of scored guesses before loss (legal 1..255).
REQ-003 SHALL port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL port: in_digits  input  4*NUM_DIGITS  BCD code; digit 0 (leftmost) in the MSB nibble.
REQ-006 SHALL port: in_valid  input  1  in_digits offered this cycle.
REQ-007 SHALL port: in_ready  output  1  engine accepts a code this cycle.
REQ-008 SHALL port: new_game  input  1  pulse: abandon the current game and return to IDLE.
REQ-009 SHALL port: bulls  output  BW=clog2(NUM_DIGITS+1)  bulls of the last scored guess.
REQ-010 SHALL port: cows  output  CW=clog2(NUM_DIGITS*(NUM_DIGITS-1)+1)  cows of the last scored guess.
REQ-011 SHALL port: score_valid  output  1  one-cycle pulse when bulls/cows update.
REQ-012 SHALL port: rejected  output  1  one-cycle pulse when an offered code is refused.
REQ-013 SHALL port: tries  output  8  count of scored guesses in the current game.
REQ-014 SHALL port: game_active, game_won, game_lost  output  1 each  status flags.
REQ-015 SHALL port: last_guess  output  4*NUM_DIGITS  last accepted guess, for the display block.

Function
REQ-016 SHALL implement the states IDLE, PLAY, SCORE and DONE.
REQ-017 SHALL define a transfer as in_valid && in_ready.
REQ-018 SHALL drive in_ready=1 in IDLE and PLAY, and 0 in SCORE and DONE.
REQ-019 SHALL, in IDLE, refuse a code containing any digit >9 by pulsing rejected one cycle later and holding state.
REQ-020 SHALL, in PLAY, refuse a code containing any digit >9 by pulsing rejected one cycle later and holding state.
REQ-021 SHALL, on an IDLE transfer, latch the code as the answer, clear tries, and enter PLAY; no score is produced.
REQ-022 SHALL, on a PLAY transfer, latch the code into last_guess and enter SCORE.
REQ-023 SHALL, in SCORE, process one guess digit per cycle over i=0..NUM_DIGITS-1.
REQ-024 SHALL add 1 to bulls when guess[i]==ans[i].
REQ-025 SHALL add to cows the count of j!=i with guess[i]==ans[j].
REQ-026 SHALL pulse score_valid with final bulls/cows exactly NUM_DIGITS+1 cycles after the transfer; tries SHALL increment on the same edge.
REQ-027 SHALL, after scoring, enter DONE with game_won=1 if bulls==NUM_DIGITS; else enter DONE with game_lost=1 if tries==MAX_TRIES; else return to PLAY.
REQ-028 SHALL hold bulls/cows/last_guess stable until the next score_valid or new_game.
REQ-029 SHALL give new_game priority over in_valid in the same cycle, from any state including mid-SCORE: go to IDLE and clear answer, tries, bulls, cows, flags and last_guess; no score_valid.
REQ-030 SHALL hold game_active=1 in PLAY and SCORE only.
REQ-031 SHALL keep tries saturating at 255 (unreachable under legal MAX_TRIES; a guard only).

Reset
REQ-032 SHALL, on reset, asynchronously force state=IDLE and zero all outputs, answer, accumulators and tries.
REQ-033 SHALL, with reset asserted mid-SCORE, produce no score_valid after release.

Configuration
REQ-034 SHALL, with BC_DUP_CHECK_EN defined, also refuse (rejected pulse, no state change) any code with a repeated digit, in both IDLE and PLAY; cows then never exceed NUM_DIGITS.
REQ-035 SHALL, without BC_DUP_CHECK_EN, accept repeated digits and score them per REQ-024/025.

Structure
REQ-036 SHALL place in shared package bc_pkg: the state enum, DIGIT_W=4, BCD_MAX=9, and width helper functions for BW/CW.
REQ-037 SHALL use one sub-module, bc_digit_cmp: one guess digit plus index vs the full answer vector -> bull bit and cow count; instanced once and time-multiplexed across SCORE cycles.
REQ-038 SHALL leave text/font rendering in the existing display block, which consumes the status outputs.

Verification (NUM_DIGITS=3, MAX_TRIES=10)
REQ-039 SHALL test: answer 0x123, guess 0x132 -> score_valid 4 cycles after the transfer, bulls=1, cows=2, tries=1, game_active=1.
REQ-040 SHALL test: answer 0x123, guess 0x123 -> bulls=3, cows=0, game_won=1, in_ready=0; in_valid then ignored.
REQ-041 SHALL test: answer 0x123, ten guesses of 0x456 -> each bulls=0, cows=0; after the 10th, game_lost=1 and tries=10.
REQ-042 SHALL test: in PLAY, guess 0x1A3 -> rejected pulse, tries unchanged, no score_valid.
REQ-043 SHALL test: answer 0x123, guess 0x112 -> with BC_DUP_CHECK_EN rejected; without it bulls=1, cows=2.
REQ-044 SHALL test: new_game, then reset, each asserted in the 2nd SCORE cycle -> IDLE, all outputs 0, no score_valid.
